// File: rtl/demux_deserializer_2ch_if.sv
// rtl/demux_deserializer_2ch_if.sv - bit-input and word-output signals of the 2-channel demux deserializer
interface demux_deserializer_2ch_if #(
  parameter int WIDTH = 8
) ();

  // serial side, sampled from the 1-to-2 demux
  logic             bit_valid;
  logic             s;
  logic             y0;
  logic             y1;
  logic             flush;

  // word side, one valid/ack pair per channel
  logic [WIDTH-1:0] word0;
  logic             word0_valid;
  logic             word0_ack;
  logic [WIDTH-1:0] word1;
  logic             word1_valid;
  logic             word1_ack;
  logic             ovf0;
  logic             ovf1;

  // producer/consumer side driving bits and acks
  modport master (
    output bit_valid, s, y0, y1, flush, word0_ack, word1_ack,
    input  word0, word0_valid, word1, word1_valid, ovf0, ovf1
  );

  // deserializer side
  modport slave (
    input  bit_valid, s, y0, y1, flush, word0_ack, word1_ack,
    output word0, word0_valid, word1, word1_valid, ovf0, ovf1
  );

endinterface

// File: rtl/demux_deserializer_2ch.sv
// rtl/demux_deserializer_2ch.sv - two-channel serial-to-word deserializer behind a 1-to-2 demux; DESER_MSB_FIRST_EN selects MSB-first assembly
module demux_deserializer_2ch #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  demux_deserializer_2ch_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // index 0 = channel 0, index 1 = channel 1
  logic [1:0][WIDTH-1:0] sr_q, sr_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][WIDTH-1:0] word_q, word_d;
  logic [1:0]            valid_q, valid_d;
  logic [1:0]            ovf_q, ovf_d;

  logic [1:0]            ack;
  logic [1:0]            in_bit;
  logic [1:0]            accept;
  logic [1:0]            done;
  logic [1:0][WIDTH-1:0] shifted;

  assign ack    = {bus.word1_ack, bus.word0_ack};
  assign in_bit = {bus.y1, bus.y0};

  // only the selected channel takes a bit, and flush drops any bit presented with it
  assign accept[0] = bus.bit_valid & ~bus.flush & ~bus.s;
  assign accept[1] = bus.bit_valid & ~bus.flush &  bus.s;

  // shift register contents including this cycle's bit; on the last bit this is the full word
  always_comb begin
    shifted = '0;
    done    = '0;
    for (int c = 0; c < 2; c++) begin
`ifdef DESER_MSB_FIRST_EN
      shifted[c] = {sr_q[c][WIDTH-2:0], in_bit[c]};
`else
      shifted[c] = {in_bit[c], sr_q[c][WIDTH-1:1]};
`endif
      done[c] = accept[c] && (cnt_q[c] == LAST_CNT);
    end
  end

  // assembly, output load, handshake and overflow per channel
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    for (int c = 0; c < 2; c++) begin
      // assembly state: flush discards partial words, completion restarts at count 0
      if (bus.flush) begin
        sr_d[c]  = '0;
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (done[c]) begin
        sr_d[c]  = '0;
        cnt_d[c] = '0;
      end else if (accept[c]) begin
        sr_d[c]  = shifted[c];
        cnt_d[c] = cnt_q[c] + CNT_ONE;
      end

      // output register: a same-cycle ack frees the slot so completions stream without a bubble
      if (done[c]) begin
        if (!valid_q[c] || ack[c]) begin
          word_d[c]  = shifted[c];
          valid_d[c] = 1'b1;
        end else begin
          ovf_d[c] = 1'b1;
        end
      end else if (valid_q[c] && ack[c]) begin
        valid_d[c] = 1'b0;
      end
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.word0       = word_q[0];
  assign bus.word0_valid = valid_q[0];
  assign bus.word1       = word_q[1];
  assign bus.word1_valid = valid_q[1];
  assign bus.ovf0        = ovf_q[0];
  assign bus.ovf1        = ovf_q[1];

endmodule

// File: tb/tb_demux_deserializer_2ch.sv
// tb/tb_demux_deserializer_2ch.sv - directed table-driven bench for demux_deserializer_2ch
module tb_demux_deserializer_2ch;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  demux_deserializer_2ch_if #(.WIDTH(8)) bus ();

  demux_deserializer_2ch #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one assembled word: bits[i] is the i-th bit sent; expected outputs after its completion edge
  typedef struct {
    bit       ch;
    bit [7:0] bits;
    bit       ack_last;
    bit       ack_after;
    bit [7:0] w0;
    bit       v0;
    bit [7:0] w1;
    bit       v1;
    bit       o0;
    bit       o1;
  } vec_t;

  vec_t vecs [6];

  // word as it appears at the output for a given send order
  function automatic bit [7:0] ew(input bit [7:0] x);
    bit [7:0] r;
`ifdef DESER_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = x[i];
`else
    r = x;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input bit [7:0] w0, input bit v0, input bit [7:0] w1,
                         input bit v1, input bit o0, input bit o1);
    chk({name, ".word0"}, 32'(bus.word0), 32'(w0));
    chk({name, ".word0_valid"}, 32'(bus.word0_valid), 32'(v0));
    chk({name, ".word1"}, 32'(bus.word1), 32'(w1));
    chk({name, ".word1_valid"}, 32'(bus.word1_valid), 32'(v1));
    chk({name, ".ovf0"}, 32'(bus.ovf0), 32'(o0));
    chk({name, ".ovf1"}, 32'(bus.ovf1), 32'(o1));
  endtask

  task automatic idle();
    bus.bit_valid = 1'b0;
    bus.s         = 1'b0;
    bus.y0        = 1'b0;
    bus.y1        = 1'b0;
    bus.flush     = 1'b0;
    bus.word0_ack = 1'b0;
    bus.word1_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // send nbits of a word to one channel; the other y line carries the inverted bit as noise
  task automatic send_bits(input bit ch, input bit [7:0] bits, input int nbits, input bit ack_last);
    for (int i = 0; i < nbits; i++) begin
      bus.bit_valid = 1'b1;
      bus.s         = ch;
      bus.y0        = ch ? ~bits[i] : bits[i];
      bus.y1        = ch ? bits[i] : ~bits[i];
      bus.word0_ack = ack_last && (i == nbits - 1) && !ch;
      bus.word1_ack = ack_last && (i == nbits - 1) && ch;
      step();
      idle();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    rst = 1'b1;

    //              ch   bits   ackL ackA  w0     v0  w1     v1  o0  o1
    vecs[0] = '{1'b0, 8'h4D, 1'b0, 1'b1, 8'h4D, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'hC3, 1'b0, 1'b0, 8'h11, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h0F, 1'b1, 1'b1, 8'h11, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0};

    step();
    step();
    chk_all("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // basic, overflow, back-to-back, channel 1
    for (int v = 0; v < 6; v++) begin
      send_bits(vecs[v].ch, vecs[v].bits, 7, 1'b0);
      if (vecs[v].ch == 1'b0)
        chk($sformatf("vec%0d.pre_valid", v), 32'(bus.word1_valid), 32'(vecs[v].v1));
      send_bits(vecs[v].ch, vecs[v].bits >> 7, 1, vecs[v].ack_last);
      chk_all($sformatf("vec%0d", v), ew(vecs[v].w0), vecs[v].v0, ew(vecs[v].w1),
              vecs[v].v1, vecs[v].o0, vecs[v].o1);
      if (vecs[v].ack_after) begin
        if (vecs[v].ch) bus.word1_ack = 1'b1;
        else            bus.word0_ack = 1'b1;
        step();
        idle();
        chk($sformatf("vec%0d.ack_clr", v),
            32'(vecs[v].ch ? bus.word1_valid : bus.word0_valid), 32'd0);
        chk($sformatf("vec%0d.ack_hold", v),
            32'(vecs[v].ch ? bus.word1 : bus.word0),
            32'(ew(vecs[v].ch ? vecs[v].w1 : vecs[v].w0)));
      end
    end

    // flush: partial word and sticky overflow are discarded, bit on the flush cycle dropped
    send_bits(1'b0, 8'hFF, 5, 1'b0);
    bus.bit_valid = 1'b1;
    bus.s         = 1'b0;
    bus.y0        = 1'b1;
    bus.flush     = 1'b1;
    step();
    idle();
    chk_all("flush", ew(8'h11), 1'b0, ew(8'h0F), 1'b0, 1'b0, 1'b0);
    send_bits(1'b0, 8'h5A, 8, 1'b0);
    chk_all("after_flush", ew(8'h5A), 1'b1, ew(8'h0F), 1'b0, 1'b0, 1'b0);
    bus.flush     = 1'b1;
    bus.word0_ack = 1'b1;
    step();
    idle();
    chk("flush_ack.valid", 32'(bus.word0_valid), 32'd0);
    chk("flush_ack.word", 32'(bus.word0), 32'(ew(8'h5A)));

    // interleave: channel 0 all ones, channel 1 all zeros
    for (int i = 0; i < 16; i++) begin
      bus.bit_valid = 1'b1;
      bus.s         = i[0];
      bus.y0        = 1'b1;
      bus.y1        = ~i[0];
      step();
      if (i == 14) begin
        chk("ilv.v0_first", 32'(bus.word0_valid), 32'd1);
        chk("ilv.v1_later", 32'(bus.word1_valid), 32'd0);
      end
    end
    idle();
    chk_all("interleave", 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    bus.word0_ack = 1'b1;
    bus.word1_ack = 1'b1;
    step();
    idle();
    chk_all("dual_ack", 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // ack with nothing valid is ignored
    bus.word0_ack = 1'b1;
    step();
    idle();
    chk_all("ack_idle", 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-word while a word is pending
    send_bits(1'b0, 8'h96, 8, 1'b0);
    chk("pre_rst.v0", 32'(bus.word0_valid), 32'd1);
    send_bits(1'b1, 8'hFF, 3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    send_bits(1'b1, 8'hC3, 7, 1'b0);
    chk("post_rst.no_early", 32'(bus.word1_valid), 32'd0);
    send_bits(1'b1, 8'hC3 >> 7, 1, 1'b0);
    chk_all("post_rst", 8'h00, 1'b0, ew(8'hC3), 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
